ej32_pfq: RTL and testbench

Byte-wide instruction prefetch queue that sits directly upstream of the eJ32 branching unit. It fetches opcode and operand bytes from the memory bus at a sequential fetch address and buffers them in a small FIFO. It presents the head byte and its address to the decode and branching stage. A jump or return from the branching stage flushes the queue and redirects fetch to the target address.

---
 rtl/ej32_pkg.sv | 13 +
 rtl/ej32_pfq_fifo.sv | 55 +++++
 rtl/ej32_pfq.sv | 113 +++++++++++
 tb/tb_ej32_pfq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ej32_pkg.sv
// Shared eJ32 types and constants used by the prefetch queue.
package ej32_pkg;

  typedef enum logic [1:0] {
    PFQ_IDLE,
    PFQ_RUN,
    PFQ_REDIR
  } pfq_state_t;

  localparam int PFQ_DEPTH = 4;
  localparam int PFQ_ASZ   = 17;

endpackage

// File: rtl/ej32_pfq_fifo.sv
// Register-file FIFO for the prefetch queue: head/tail pointers, occupancy count,
// synchronous clear that takes priority over write and pop.
module ej32_pfq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 25
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   wr,
  input  logic [W-1:0]           wdata,
  input  logic                   rd,
  output logic                   vld,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          do_rd;

  assign vld   = (cnt != '0);
  assign do_rd = rd & vld;
  assign rdata = mem[head];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (wr) begin
        mem[tail] <= wdata;
        tail      <= tail + AW'(1);
      end
      if (do_rd) head <= head + AW'(1);
      case ({wr, do_rd})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ej32_pfq.sv
// eJ32 instruction prefetch queue: sequential byte fetch into a small FIFO, flushed
// and redirected by the branching unit. Optional same-cycle bypass: EJ32_PFQ_BYPASS_EN.
module ej32_pfq
  import ej32_pkg::*;
#(
  parameter int ASZ   = PFQ_ASZ,
  parameter int DEPTH = PFQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   mem_req_o,
  output logic [ASZ-1:0]         mem_addr_o,
  input  logic [7:0]             mem_data_i,
  input  logic                   flush,
  input  logic [ASZ-1:0]         flush_addr,
  input  logic                   deq,
  output logic                   q_vld_o,
  output logic [7:0]             q_data_o,
  output logic [ASZ-1:0]         q_pc_o,
  output logic [$clog2(DEPTH):0] q_cnt_o,
  output pfq_state_t             dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  pfq_state_t     state;
  pfq_state_t     state_nxt;
  logic [ASZ-1:0] f;
  logic [ASZ-1:0] ret_addr;
  logic           inflight;
  logic           kill;
  logic           issue;
  logic           ret;
  logic           fifo_wr;
  logic           fifo_rd;
  logic           fifo_vld;
  logic [ASZ+7:0] fifo_rdata;
  logic [CW-1:0]  fifo_cnt;
  logic [CW:0]    occ;

  // A flush only acts while the unit is enabled.
  assign kill  = flush & en;
  assign occ   = {1'b0, fifo_cnt} + {{CW{1'b0}}, inflight};
  assign issue = en & (state != PFQ_IDLE) & (occ < (CW+1)'(DEPTH));
  assign ret   = inflight & ~kill;

  always_comb begin
    state_nxt = state;
    unique case (state)
      PFQ_IDLE:  if (kill) state_nxt = PFQ_REDIR;
                 else if (en) state_nxt = PFQ_RUN;
      PFQ_RUN:   if (kill) state_nxt = PFQ_REDIR;
                 else if (!en && !inflight) state_nxt = PFQ_IDLE;
      PFQ_REDIR: if (kill) state_nxt = PFQ_REDIR;
                 else if (en) state_nxt = PFQ_RUN;
      default:   state_nxt = PFQ_IDLE;
    endcase
  end

  // A request issued in the flush cycle is never marked in flight, so its byte is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PFQ_IDLE;
      f        <= '0;
      ret_addr <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue & ~kill;
      if (issue) ret_addr <= f;
      if (kill) f <= flush_addr;
      else if (issue) f <= f + ASZ'(1);
    end
  end

  assign fifo_rd = deq & ~kill;

`ifdef EJ32_PFQ_BYPASS_EN
  logic byp;
  assign byp      = ret & ~fifo_vld;
  assign fifo_wr  = ret & ~(byp & deq);
  assign q_vld_o  = fifo_vld | byp;
  assign q_data_o = byp ? mem_data_i : fifo_rdata[7:0];
  assign q_pc_o   = byp ? ret_addr : fifo_rdata[ASZ+7:8];
`else
  assign fifo_wr  = ret;
  assign q_vld_o  = fifo_vld;
  assign q_data_o = fifo_rdata[7:0];
  assign q_pc_o   = fifo_rdata[ASZ+7:8];
`endif

  ej32_pfq_fifo #(
    .DEPTH (DEPTH),
    .W     (ASZ + 8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (kill),
    .wr    (fifo_wr),
    .wdata ({ret_addr, mem_data_i}),
    .rd    (fifo_rd),
    .vld   (fifo_vld),
    .rdata (fifo_rdata),
    .cnt   (fifo_cnt)
  );

  assign mem_req_o  = issue;
  assign mem_addr_o = f;
  assign q_cnt_o    = fifo_cnt;
  assign dbg_state  = state;

endmodule

// File: tb/tb_ej32_pfq.sv
// Bench for ej32_pfq: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a queue-based reference model.
module tb_ej32_pfq;
  import ej32_pkg::*;

  localparam int ASZ   = 17;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           en = 1'b0;
  logic           flush = 1'b0;
  logic [ASZ-1:0] flush_addr = '0;
  logic           deq = 1'b0;
  logic [7:0]     mem_data_i = '0;
  logic           mem_req_o;
  logic [ASZ-1:0] mem_addr_o;
  logic           q_vld_o;
  logic [7:0]     q_data_o;
  logic [ASZ-1:0] q_pc_o;
  logic [CW-1:0]  q_cnt_o;
  pfq_state_t     dbg_state;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of {pc, byte}, fetch pointer, in-flight flag, mode.
  logic [ASZ+7:0] exp_q[$];
  logic [ASZ-1:0] m_f;
  logic [ASZ-1:0] m_ret_addr;
  bit             m_infl;
  int             m_mode;   // 0 idle, 1 run, 2 redirect

  bit             last_req;
  logic [ASZ-1:0] last_addr;
  logic [ASZ-1:0] req_log[$];

  ej32_pfq #(.ASZ(ASZ), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_i (mem_data_i),
    .flush      (flush),
    .flush_addr (flush_addr),
    .deq        (deq),
    .q_vld_o    (q_vld_o),
    .q_data_o   (q_data_o),
    .q_pc_o     (q_pc_o),
    .q_cnt_o    (q_cnt_o),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_f        = '0;
    m_ret_addr = '0;
    m_infl     = 1'b0;
    m_mode     = 0;
  endtask

  task automatic model_cycle();
    int             n;
    bit             fe, ret, iss, e_vld, byp;
    logic [ASZ+7:0] e_head, ret_word;
    n        = exp_q.size();
    fe       = flush && en;
    ret      = m_infl;
    byp      = 1'b0;
    e_vld    = 1'b0;
    e_head   = '0;
    ret_word = {m_ret_addr, mem_data_i};
    iss      = en && (m_mode != 0) && (n + int'(m_infl) < DEPTH);
    if (n > 0) begin
      e_vld  = 1'b1;
      e_head = exp_q[0];
    end
`ifdef EJ32_PFQ_BYPASS_EN
    else if (ret && !fe) begin
      e_vld  = 1'b1;
      e_head = ret_word;
      byp    = 1'b1;
    end
`endif
    check("req", mem_req_o, iss);
    if (iss) check("addr", mem_addr_o, m_f);
    check("cnt", q_cnt_o, n);
    check("vld", q_vld_o, e_vld);
    if (e_vld) begin
      check("data", q_data_o, e_head[7:0]);
      check("pc", q_pc_o, e_head[ASZ+7:8]);
    end
    if (fe) exp_q.delete();
    else begin
      if (deq && n > 0) void'(exp_q.pop_front());
      if (ret && !(byp && deq)) exp_q.push_back(ret_word);
    end
    case (m_mode)
      0:       m_mode = fe ? 2 : (en ? 1 : 0);
      1:       m_mode = fe ? 2 : ((!en && !m_infl) ? 0 : 1);
      default: m_mode = fe ? 2 : (en ? 1 : 2);
    endcase
    if (iss) m_ret_addr = m_f;
    m_f    = fe ? flush_addr : (iss ? m_f + 17'd1 : m_f);
    m_infl = iss && !fe;
  endtask

  // Compare process: checks every cycle on the falling edge.
  always @(negedge clk) begin
    last_req  = mem_req_o;
    last_addr = mem_addr_o;
    if (!rst_n) begin
      model_reset();
      check("rst_req", mem_req_o, 0);
      check("rst_vld", q_vld_o, 0);
      check("rst_cnt", q_cnt_o, 0);
      check("rst_state", dbg_state, PFQ_IDLE);
    end else begin
      model_cycle();
    end
  end

  // Driver tasks: memory answers the previous cycle's request, otherwise junk.
  task automatic tick();
    @(posedge clk);
    #1;
    mem_data_i = last_req ? last_addr[7:0] : 8'($urandom);
  endtask

  task automatic cyc(input bit e, input bit d, input bit fl, input logic [ASZ-1:0] fa);
    tick();
    en = e; deq = d; flush = fl; flush_addr = fa;
  endtask

  task automatic cyc_chk(input bit e, input bit d, input bit fl, input logic [ASZ-1:0] fa);
    cyc(e, d, fl, fa);
    @(negedge clk);
    #1;
  endtask

  initial begin
    bit hit;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("t1_rst_addr", mem_addr_o, 0);
    check("t1_rst_data", q_data_o, 0);
    check("t1_rst_pc", q_pc_o, 0);
    rst_n = 1'b1; en = 1'b1;

    // Test 1: fill with no consumer; exactly four requests 0..3
    for (int i = 0; i < 10; i++) begin
      cyc_chk(1, 0, 0, '0);
      if (mem_req_o) req_log.push_back(mem_addr_o);
    end
    check("t1_nreq", req_log.size(), 4);
    for (int i = 0; i < req_log.size() && i < 4; i++) check("t1_reqaddr", req_log[i], i);
    check("t1_cnt", q_cnt_o, 4);
    check("t1_data", q_data_o, 8'h00);
    check("t1_pc", q_pc_o, 0);
    check("t1_req_low", mem_req_o, 0);

    // Test 2: continuous dequeue, one byte per cycle, no bubbles
    for (int k = 0; k < 8; k++) begin
      cyc_chk(1, 1, 0, '0);
      check("t2_vld", q_vld_o, 1);
      check("t2_data", q_data_o, k);
      check("t2_pc", q_pc_o, k);
    end

    // Test 3 (and deq+flush): flush with a fetch in flight
    cyc_chk(1, 1, 1, 17'h00120);
    cyc_chk(1, 0, 0, '0);
    check("t3_req", mem_req_o, 1);
    check("t3_addr", mem_addr_o, 17'h00120);
    check("t3_cnt", q_cnt_o, 0);
    check("t3_vld_empty", q_vld_o, 0);
    cyc_chk(1, 0, 0, '0);
`ifdef EJ32_PFQ_BYPASS_EN
    check("t3_byp_vld", q_vld_o, 1);
    check("t3_byp_data", q_data_o, 8'h20);
`else
    check("t3_vld_n2", q_vld_o, 0);
`endif
    cyc_chk(1, 0, 0, '0);
    check("t3_vld", q_vld_o, 1);
    check("t3_data", q_data_o, 8'h20);
    check("t3_pc", q_pc_o, 17'h00120);

    // Test 4: address wrap at the top of the space
    cyc(1, 0, 1, 17'h1FFFE);
    req_log.delete();
    for (int i = 0; i < 8; i++) begin
      cyc_chk(1, 0, 0, '0);
      if (mem_req_o) req_log.push_back(mem_addr_o);
    end
    check("t4_nreq", req_log.size(), 4);
    if (req_log.size() == 4) begin
      check("t4_a0", req_log[0], 17'h1FFFE);
      check("t4_a1", req_log[1], 17'h1FFFF);
      check("t4_a2", req_log[2], 17'h00000);
      check("t4_a3", req_log[3], 17'h00001);
    end
    for (int k = 0; k < 4; k++) begin
      cyc_chk(1, 1, 0, '0);
      check("t4_pc", q_pc_o, (17'h1FFFE + k) & 17'h1FFFF);
      check("t4_data", q_data_o, (8'hFE + k) & 8'hFF);
    end

    // Test 5: drain with the unit disabled, then deq on empty
    for (int i = 0; i < 8; i++) cyc_chk(0, 1, 0, '0);
    check("t5_drained", q_cnt_o, 0);
    check("t5_idle", dbg_state, PFQ_IDLE);
    for (int i = 0; i < 2; i++) begin
      cyc_chk(0, 1, 0, '0);
      check("t5_empty_cnt", q_cnt_o, 0);
      check("t5_empty_vld", q_vld_o, 0);
    end
    for (int i = 0; i < 8; i++) cyc_chk(1, 0, 0, '0);
    check("t5_refill", q_cnt_o, 4);
    cyc_chk(1, 1, 1, 17'h00040);
    cyc_chk(1, 0, 0, '0);
    check("t5_flush_cnt", q_cnt_o, 0);
    check("t5_flush_vld", q_vld_o, 0);
    check("t5_flush_addr", mem_addr_o, 17'h00040);

    // Test 6: asynchronous reset with three entries queued
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cyc_chk(1, 0, 0, '0);
      if (q_cnt_o == 3) hit = 1'b1;
    end
    check("t6_reach3", hit, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_req", mem_req_o, 0);
    check("t6_addr", mem_addr_o, 0);
    check("t6_vld", q_vld_o, 0);
    check("t6_data", q_data_o, 0);
    check("t6_pc", q_pc_o, 0);
    check("t6_cnt", q_cnt_o, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      cyc_chk(1, 0, 0, '0);
      if (q_vld_o) begin
        hit = 1'b1;
        check("t6_first_pc", q_pc_o, 0);
        check("t6_first_data", q_data_o, 0);
      end
    end
    check("t6_seen", hit, 1);

    // Test 7: back-to-back flushes, newer target wins
    cyc_chk(1, 0, 1, 17'h00200);
    cyc_chk(1, 0, 1, 17'h00305);
    cyc_chk(1, 0, 0, '0);
    check("t7_addr", mem_addr_o, 17'h00305);
    cyc_chk(1, 0, 0, '0);
    cyc_chk(1, 0, 0, '0);
    check("t7_pc", q_pc_o, 17'h00305);
    check("t7_data", q_data_o, 8'h05);

    // Randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      logic [ASZ-1:0] fa;
      fa = ($urandom_range(0, 3) == 0) ? 17'h1FFFC + 17'($urandom_range(0, 3)) : 17'($urandom);
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, fa);
    end
    cyc(1, 0, 0, '0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
